// File: rtl/stack_pop_reader_if.sv
// Storage read port (rd/empty/r_data) plus the valid/ready output stream of stack_pop_reader.
// STACK_POP_READER_LAST_EN adds the m_last sideband to the stream.
interface stack_pop_reader_if #(
   parameter int B = 4
);
   logic         rd;
   logic         empty;
   logic [B-1:0] r_data;
   logic [B-1:0] m_data;
   logic         m_valid;
   logic         m_ready;
`ifdef STACK_POP_READER_LAST_EN
   logic         m_last;

   modport master (
      output rd, m_data, m_valid, m_last,
      input  empty, r_data, m_ready
   );

   modport slave (
      input  rd, m_data, m_valid, m_last,
      output empty, r_data, m_ready
   );
`else
   modport master (
      output rd, m_data, m_valid,
      input  empty, r_data, m_ready
   );

   modport slave (
      input  rd, m_data, m_valid,
      output empty, r_data, m_ready
   );
`endif
endinterface

// File: rtl/stack_pop_reader.sv
// Pops a requested burst of words from 1-cycle-latency block-RAM storage into a 2-entry output FIFO.
// Optional macro STACK_POP_READER_LAST_EN tags the final word of each burst with m_last.
module stack_pop_reader #(
   parameter int B     = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [CNT_W-1:0]   count,
   output logic               busy,
   output logic               done,
   stack_pop_reader_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             in_flight_q, in_flight_d;
   logic [1:0]       occ_q,       occ_d;
   logic             head_q,      head_d;
   logic             tail_q,      tail_d;
   logic [B-1:0]     buf_data_q [2];
   logic [B-1:0]     buf_data_d [2];
`ifdef STACK_POP_READER_LAST_EN
   logic             last_flight_q, last_flight_d;
   logic             buf_last_q [2];
   logic             buf_last_d [2];
`endif

   logic       xfer;
   logic       last_pop;
   logic [1:0] committed;

   assign bus.m_valid = (occ_q != 2'd0);
   assign bus.m_data  = buf_data_q[head_q];
`ifdef STACK_POP_READER_LAST_EN
   assign bus.m_last  = buf_last_q[head_q];
`endif

   assign xfer = bus.m_valid & bus.m_ready;
   // A head word leaving this cycle frees its slot before the in-flight word can land,
   // so counting it keeps the 1 word/cycle stream while still guaranteeing a landing slot.
   assign committed = occ_q + {1'b0, in_flight_q} - {1'b0, xfer};
   assign last_pop  = bus.rd && (remaining_q == CNT_W'(1));

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         in_flight_q <= 1'b0;
         occ_q       <= 2'd0;
         head_q      <= 1'b0;
         tail_q      <= 1'b0;
         // NOTE: the buffer is reset only because m_data must read 0 after reset; larger storage would not be.
         buf_data_q[0] <= '0;
         buf_data_q[1] <= '0;
`ifdef STACK_POP_READER_LAST_EN
         last_flight_q <= 1'b0;
         buf_last_q[0] <= 1'b0;
         buf_last_q[1] <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         in_flight_q <= in_flight_d;
         occ_q       <= occ_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         buf_data_q  <= buf_data_d;
`ifdef STACK_POP_READER_LAST_EN
         last_flight_q <= last_flight_d;
         buf_last_q    <= buf_last_d;
`endif
      end
   end

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (count != '0) ? S_POP : S_DONE;
         S_POP:   if (last_pop) state_d = S_DRAIN;
         S_DRAIN: if (!in_flight_q && (occ_q == 2'd0)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      bus.rd = 1'b0;
      case (state_q)
         S_POP: begin
            busy   = 1'b1;
            bus.rd = (remaining_q != '0) && !bus.empty && (committed < 2'd2);
         end
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      remaining_d = remaining_q;
      if ((state_q == S_IDLE) && start) begin
         remaining_d = count;
      end else if (bus.rd) begin
         remaining_d = remaining_q - CNT_W'(1);
      end

      in_flight_d = bus.rd;
      occ_d       = committed;
      head_d      = head_q ^ xfer;
      tail_d      = tail_q ^ in_flight_q;

      buf_data_d = buf_data_q;
      if (in_flight_q) buf_data_d[tail_q] = bus.r_data;
`ifdef STACK_POP_READER_LAST_EN
      last_flight_d = last_pop;
      buf_last_d    = buf_last_q;
      if (in_flight_q) buf_last_d[tail_q] = last_flight_q;
`endif
   end

endmodule

// File: tb/tb_stack_pop_reader.sv
// Bench for stack_pop_reader: storage model, stream monitor and a word-order reference built from storage contents.
// Expected stream for a burst of n words = the next n stored words in pop order, last flag on word n-1.
module tb_stack_pop_reader;

   localparam int B     = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             done;

   stack_pop_reader_if #(.B(B)) bus ();

   stack_pop_reader #(.B(B), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .count (count),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   int tests_run = 0;
   int failed    = 0;

   // Storage model: words pop in load order, data appears the cycle after an accepted pop.
   logic [B-1:0] mem [0:2047];
   int           store_len   = 0;
   int           pop_ptr     = 0;
   logic         force_empty = 1'b0;

   assign bus.empty = force_empty || (pop_ptr >= store_len);

   always @(posedge clk) begin
      if (bus.rd && !bus.empty) begin
         bus.r_data <= mem[pop_ptr];
         pop_ptr    <= pop_ptr + 1;
      end
   end

   // Monitor, sampled on the falling edge.
   int           cyc = 0;
   int           pops, xfers, dones, busy_cnt;
   int           rd_empty_err, hold_err, overflow_err;
   int           start_cyc, first_valid_cyc;
   logic [B-1:0] got_q [$];
   bit           got_last [$];
   int           pop_cyc [$];
   int           xfer_cyc [$];
   int           done_cyc [$];
   bit           prev_stall = 1'b0;
   logic [B-1:0] prev_data;
   bit           last_now;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
`ifdef STACK_POP_READER_LAST_EN
         last_now = bus.m_last;
`else
         last_now = 1'b0;
`endif
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (start) start_cyc = cyc;
            if (bus.rd) begin
               pops++;
               pop_cyc.push_back(cyc);
               if (bus.empty) rd_empty_err++;
            end
            if (bus.m_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
            if (prev_stall && (!bus.m_valid || (bus.m_data !== prev_data))) hold_err++;
            if (bus.m_valid && bus.m_ready) begin
               xfers++;
               got_q.push_back(bus.m_data);
               got_last.push_back(last_now);
               xfer_cyc.push_back(cyc);
            end
            if (pops - xfers > 2) overflow_err++;
            if (done) begin
               dones++;
               done_cyc.push_back(cyc);
            end
            if (busy) busy_cnt++;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
         end
      end
   end

   task automatic clear_mon();
      pops = 0; xfers = 0; dones = 0; busy_cnt = 0;
      rd_empty_err = 0; hold_err = 0; overflow_err = 0;
      start_cyc = -1; first_valid_cyc = -1;
      got_q.delete(); got_last.delete();
      pop_cyc.delete(); xfer_cyc.delete(); done_cyc.delete();
   endtask

   task automatic load_random(input int n);
      for (int i = 0; i < n; i++) begin
         mem[store_len] = B'($urandom_range(0, 15));
         store_len++;
      end
   endtask

   task automatic load_word(input logic [B-1:0] w);
      mem[store_len] = w;
      store_len++;
   endtask

   task automatic start_burst(input int c);
      @(posedge clk); #2;
      start = 1'b1;
      count = CNT_W'(c);
      @(posedge clk); #2;
      start = 1'b0;
      count = CNT_W'($urandom);
   endtask

   task automatic drive_until_done(input int budget, input bit rnd, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         if (rnd) begin
            bus.m_ready = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 4) == 0);
         end
         if (dones != 0) begin
            timed_out = 1'b0;
            break;
         end
      end
      bus.m_ready = 1'b1;
      force_empty = 1'b0;
      repeat (4) @(posedge clk);
      #2;
   endtask

   // Mismatches between the captured stream and the next n stored words starting at p0.
   function automatic int stream_errs(input int p0, input int n);
      int errs = 0;
      if (got_q.size() != n) return 1000 + got_q.size();
      for (int i = 0; i < n; i++) begin
         if (got_q[i] !== mem[p0 + i]) errs++;
`ifdef STACK_POP_READER_LAST_EN
         if (got_last[i] !== (i == n - 1)) errs++;
`endif
      end
      return errs;
   endfunction

   task automatic expect_int(input string name, input int actual, input int required);
      tests_run++;
      if (actual !== required) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, required);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; count = '0;
      bus.m_ready = 1'b1; force_empty = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      tests_run++;
      if ({busy, done, bus.rd, bus.m_valid} !== 4'b0000) begin
         failed++;
         $display("FAIL reset_ctrl: got %b, expected 0000", {busy, done, bus.rd, bus.m_valid});
      end
      tests_run++;
      if (bus.m_data !== '0) begin
         failed++;
         $display("FAIL reset_m_data: got %h, expected 0", bus.m_data);
      end
`ifdef STACK_POP_READER_LAST_EN
      tests_run++;
      if (bus.m_last !== 1'b0) begin
         failed++;
         $display("FAIL reset_m_last: got %b, expected 0", bus.m_last);
      end
`endif
      reset = 1'b0;
   endtask

   // Start accepted at the end of cycle S: pops in S+1..S+3, words land two edges later.
   task automatic test_basic();
      int  p0;
      int  s;
      bit  to;
      bit  ok;
      clear_mon();
      p0 = pop_ptr;
      load_word(4'hA); load_word(4'hB); load_word(4'hC);
      bus.m_ready = 1'b1;
      start_burst(3);
      drive_until_done(40, 1'b0, to);
      s = start_cyc;
      expect_int("basic_timeout", int'(to), 0);
      ok = (pop_cyc.size() == 3);
      for (int i = 0; ok && i < 3; i++) ok = (pop_cyc[i] == s + 1 + i);
      expect_int("basic_rd_consecutive", int'(ok), 1);
      ok = (xfer_cyc.size() == 3);
      for (int i = 0; ok && i < 3; i++) ok = (xfer_cyc[i] == s + 3 + i);
      expect_int("basic_xfer_cycles", int'(ok), 1);
      expect_int("basic_first_valid", first_valid_cyc - s, 3);
      expect_int("basic_stream", stream_errs(p0, 3), 0);
      expect_int("basic_done_count", dones, 1);
      expect_int("basic_done_after_last", int'((done_cyc.size() == 1) && (xfer_cyc.size() == 3)
                 && (done_cyc[0] > xfer_cyc[2])), 1);
      expect_int("basic_busy_after", int'(busy), 0);
   endtask

   task automatic test_backpressure();
      int p0;
      bit to;
      clear_mon();
      p0 = pop_ptr;
      load_random(4);
      bus.m_ready = 1'b0;
      start_burst(4);
      repeat (5) @(posedge clk);
      #2;
      expect_int("stall_pops", pops, 2);
      expect_int("stall_valid", int'(bus.m_valid), 1);
      expect_int("stall_head_word", int'(bus.m_data), int'(mem[p0]));
      bus.m_ready = 1'b1;
      drive_until_done(40, 1'b0, to);
      expect_int("stall_timeout", int'(to), 0);
      expect_int("stall_stream", stream_errs(p0, 4), 0);
      expect_int("stall_hold", hold_err, 0);
      expect_int("stall_done_count", dones, 1);
   endtask

   task automatic test_empty_stall();
      int p0;
      bit to;
      clear_mon();
      p0 = pop_ptr;
      load_random(2);
      force_empty = 1'b1;
      bus.m_ready = 1'b1;
      start_burst(2);
      repeat (6) @(posedge clk);
      #2;
      expect_int("empty_pops", pops, 0);
      expect_int("empty_busy", int'(busy), 1);
      force_empty = 1'b0;
      drive_until_done(40, 1'b0, to);
      expect_int("empty_timeout", int'(to), 0);
      expect_int("empty_stream", stream_errs(p0, 2), 0);
      expect_int("empty_rd_gated", rd_empty_err, 0);
      expect_int("empty_done_count", dones, 1);
   endtask

   task automatic test_zero_count();
      bit to;
      clear_mon();
      load_random(2);
      start_burst(0);
      drive_until_done(20, 1'b0, to);
      expect_int("zero_timeout", int'(to), 0);
      expect_int("zero_pops", pops, 0);
      expect_int("zero_no_valid", first_valid_cyc, -1);
      expect_int("zero_done_latency", (done_cyc.size() == 1) ? done_cyc[0] - start_cyc : -1, 1);
      expect_int("zero_busy", busy_cnt, 0);
   endtask

   task automatic test_reset_mid();
      int p0;
      bit to;
      bit reached;
      clear_mon();
      load_random(5);
      bus.m_ready = 1'b1;
      start_burst(5);
      reached = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #2;
         if (xfers >= 2) begin
            reached = 1'b1;
            break;
         end
      end
      expect_int("midrst_two_xfers", int'(reached), 1);
      reset = 1'b1;
      @(posedge clk); #2;
      tests_run++;
      if ({busy, done, bus.rd, bus.m_valid, bus.m_data} !== '0) begin
         failed++;
         $display("FAIL midrst_outputs: got %b, expected 0", {busy, done, bus.rd, bus.m_valid, bus.m_data});
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      expect_int("midrst_no_done", dones, 0);
      clear_mon();
      load_random(1);
      p0 = pop_ptr;
      start_burst(1);
      drive_until_done(40, 1'b0, to);
      expect_int("midrst_timeout", int'(to), 0);
      expect_int("midrst_restart_stream", stream_errs(p0, 1), 0);
      expect_int("midrst_restart_done", dones, 1);
   endtask

   task automatic test_busy_start();
      int p0;
      bit to;
      clear_mon();
      p0 = pop_ptr;
      load_random(3);
      load_random(6);
      bus.m_ready = 1'b1;
      start_burst(3);
      start = 1'b1;
      count = CNT_W'(7);
      @(posedge clk); #2;
      start = 1'b0;
      drive_until_done(40, 1'b0, to);
      repeat (6) @(posedge clk);
      #2;
      expect_int("busy_start_timeout", int'(to), 0);
      expect_int("busy_start_pops", pops, 3);
      expect_int("busy_start_stream", stream_errs(p0, 3), 0);
      expect_int("busy_start_done", dones, 1);
   endtask

   task automatic test_random();
      int p0;
      int c;
      bit to;
      for (int k = 0; k < 6; k++) begin
         clear_mon();
         c  = $urandom_range(1, 12);
         p0 = pop_ptr;
         load_random(c + $urandom_range(0, 2));
         start_burst(c);
         drive_until_done(400, 1'b1, to);
         expect_int("rand_timeout", int'(to), 0);
         expect_int("rand_stream", stream_errs(p0, c), 0);
         expect_int("rand_done", dones, 1);
         expect_int("rand_rd_gated", rd_empty_err, 0);
         expect_int("rand_hold", hold_err, 0);
         expect_int("rand_landing", overflow_err, 0);
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_basic();
      test_backpressure();
      test_empty_stall();
      test_zero_count();
      test_reset_mid();
      test_busy_start();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
